// File: rtl/gate_bus_arbiter_if.sv
// Handshake bundle for gate_bus_arbiter: two operand requesters, one result consumer.
// The arbiter takes the slave modport; the requesters/consumer side takes master.
interface gate_bus_arbiter_if #(
    parameter int NrOfBits  = 8,
    parameter int CountBits = 16
);
    logic                 req0_valid;
    logic                 req0_ready;
    logic [NrOfBits-1:0]  req0_a;
    logic [NrOfBits-1:0]  req0_b;
    logic [1:0]           req0_bubbles;

    logic                 req1_valid;
    logic                 req1_ready;
    logic [NrOfBits-1:0]  req1_a;
    logic [NrOfBits-1:0]  req1_b;
    logic [1:0]           req1_bubbles;

    logic                 res_valid;
    logic                 res_ready;
    logic [NrOfBits-1:0]  res_data;
    logic                 res_src;
    logic [CountBits-1:0] op_count;

    modport master (
        output req0_valid, req0_a, req0_b, req0_bubbles,
        output req1_valid, req1_a, req1_b, req1_bubbles,
        output res_ready,
        input  req0_ready, req1_ready,
        input  res_valid, res_data, res_src, op_count
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_bubbles,
        input  req1_valid, req1_a, req1_b, req1_bubbles,
        input  res_ready,
        output req0_ready, req1_ready,
        output res_valid, res_data, res_src, op_count
    );
endinterface

// File: rtl/gate_bus_arbiter.sv
// Two-requester round-robin arbiter sharing one bitwise OR gate with a registered result.
// Define GATE_ARB_BUBBLE_EN to honour the per-operand invert (bubble) controls.
module gate_bus_arbiter #(
    parameter int NrOfBits  = 8,
    parameter int CountBits = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    gate_bus_arbiter_if.slave    bus
);
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam logic [CountBits-1:0] CountMax = {CountBits{1'b1}};

    state_t               state, state_next;
    logic                 last, last_next;
    logic [NrOfBits-1:0]  data, data_next;
    logic                 src, src_next;
    logic [CountBits-1:0] count, count_next;

    logic                 can_accept;
    logic                 consume;
    logic                 grant0, grant1;
    logic [NrOfBits-1:0]  sel_a, sel_b;
    logic [NrOfBits-1:0]  real_a, real_b;

    // Arbitration: contention goes to whichever requester was not served last.
    always_comb begin
        can_accept = (state == EMPTY) || bus.res_ready;
        grant0     = 1'b0;
        grant1     = 1'b0;
        if (!reset && can_accept) begin
            if (bus.req0_valid && bus.req1_valid) begin
                grant0 = last;
                grant1 = !last;
            end else begin
                grant0 = bus.req0_valid;
                grant1 = bus.req1_valid;
            end
        end
    end

`ifdef GATE_ARB_BUBBLE_EN
    logic [1:0] sel_bubbles;

    always_comb begin
        sel_a       = grant1 ? bus.req1_a       : bus.req0_a;
        sel_b       = grant1 ? bus.req1_b       : bus.req0_b;
        sel_bubbles = grant1 ? bus.req1_bubbles : bus.req0_bubbles;
        real_a      = sel_bubbles[0] ? ~sel_a : sel_a;
        real_b      = sel_bubbles[1] ? ~sel_b : sel_b;
    end
`else
    logic unused_bubbles;
    assign unused_bubbles = ^{bus.req0_bubbles, bus.req1_bubbles};

    always_comb begin
        sel_a  = grant1 ? bus.req1_a : bus.req0_a;
        sel_b  = grant1 ? bus.req1_b : bus.req0_b;
        real_a = sel_a;
        real_b = sel_b;
    end
`endif

    // A grant reloads the result register even while the old result drains.
    always_comb begin
        consume    = (state == FULL) && bus.res_ready;
        state_next = state;
        last_next  = last;
        data_next  = data;
        src_next   = src;
        count_next = count;
        if (consume && (count != CountMax)) begin
            count_next = count + {{(CountBits-1){1'b0}}, 1'b1};
        end
        if (grant0 || grant1) begin
            state_next = FULL;
            data_next  = real_a | real_b;
            src_next   = grant1;
            last_next  = grant1;
        end else if (consume) begin
            state_next = EMPTY;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= EMPTY;
            last  <= 1'b1;
            data  <= '0;
            src   <= 1'b0;
            count <= '0;
        end else begin
            state <= state_next;
            last  <= last_next;
            data  <= data_next;
            src   <= src_next;
            count <= count_next;
        end
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.res_valid  = (state == FULL);
    assign bus.res_data   = data;
    assign bus.res_src    = src;
    assign bus.op_count   = count;
endmodule

// File: tb/tb_gate_bus_arbiter.sv
// Randomized bench for gate_bus_arbiter against a transaction-level reference model.
// A second instance with a 2-bit counter sees the same stimulus to exercise saturation.
module tb_gate_bus_arbiter;
    localparam int NB = 8;

    logic clock;
    logic reset;

    gate_bus_arbiter_if #(.NrOfBits(NB), .CountBits(16)) bus_m ();
    gate_bus_arbiter_if #(.NrOfBits(NB), .CountBits(2))  bus_s ();

    gate_bus_arbiter #(.NrOfBits(NB), .CountBits(16)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_m.slave)
    );

    gate_bus_arbiter #(.NrOfBits(NB), .CountBits(2)) dut_sat (
        .clock (clock),
        .reset (reset),
        .bus   (bus_s.slave)
    );

    assign bus_s.req0_valid   = bus_m.req0_valid;
    assign bus_s.req0_a       = bus_m.req0_a;
    assign bus_s.req0_b       = bus_m.req0_b;
    assign bus_s.req0_bubbles = bus_m.req0_bubbles;
    assign bus_s.req1_valid   = bus_m.req1_valid;
    assign bus_s.req1_a       = bus_m.req1_a;
    assign bus_s.req1_b       = bus_m.req1_b;
    assign bus_s.req1_bubbles = bus_m.req1_bubbles;
    assign bus_s.res_ready    = bus_m.res_ready;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: result slot contents, round-robin memory and a plain integer count.
    bit        m_full;
    bit [7:0]  m_data;
    bit        m_src;
    bit        m_last;
    int        m_count;
    bit        obs_r0, obs_r1;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    function automatic bit [7:0] gateOr(input bit [7:0] a, input bit [7:0] b, input bit [1:0] bub);
        bit [7:0] ra, rb;
        ra = a;
        rb = b;
`ifdef GATE_ARB_BUBBLE_EN
        if (bub[0]) ra = ~a;
        if (bub[1]) rb = ~b;
`else
        bub = 2'b00;
`endif
        return ra | rb;
    endfunction

    task automatic applyStimulus(
        input bit rst, input bit v0, input bit v1,
        input bit [7:0] a0, input bit [7:0] b0, input bit [1:0] u0,
        input bit [7:0] a1, input bit [7:0] b1, input bit [1:0] u1,
        input bit rr
    );
        int  winner;
        bit  consume;
        @(negedge clock);
        reset              = rst;
        bus_m.req0_valid   = v0;
        bus_m.req1_valid   = v1;
        bus_m.req0_a       = a0;
        bus_m.req0_b       = b0;
        bus_m.req0_bubbles = u0;
        bus_m.req1_a       = a1;
        bus_m.req1_b       = b1;
        bus_m.req1_bubbles = u1;
        bus_m.res_ready    = rr;
        #1;
        // Winner: -1 none, else index. Slot can take work if empty or draining.
        winner = -1;
        if (!rst && (!m_full || rr)) begin
            if (v0 && v1) winner = (m_last == 1'b1) ? 0 : 1;
            else if (v0)  winner = 0;
            else if (v1)  winner = 1;
        end
        obs_r0 = bus_m.req0_ready;
        obs_r1 = bus_m.req1_ready;
        checkOutput("req0_ready", {63'd0, bus_m.req0_ready}, {63'd0, winner == 0});
        checkOutput("req1_ready", {63'd0, bus_m.req1_ready}, {63'd0, winner == 1});
        @(posedge clock);
        if (rst) begin
            m_full  = 0;
            m_data  = 8'h00;
            m_src   = 0;
            m_last  = 1;
            m_count = 0;
        end else begin
            consume = m_full && rr;
            if (consume) m_count++;
            if (winner == 0) begin
                m_data = gateOr(a0, b0, u0);
                m_src  = 0;
                m_last = 0;
                m_full = 1;
            end else if (winner == 1) begin
                m_data = gateOr(a1, b1, u1);
                m_src  = 1;
                m_last = 1;
                m_full = 1;
            end else if (consume) begin
                m_full = 0;
            end
        end
        #1;
        checkOutput("res_valid", {63'd0, bus_m.res_valid}, {63'd0, m_full});
        checkOutput("res_data",  {56'd0, bus_m.res_data},  {56'd0, m_data});
        checkOutput("res_src",   {63'd0, bus_m.res_src},   {63'd0, m_src});
        checkOutput("op_count",  {48'd0, bus_m.op_count},  64'(m_count));
        checkOutput("op_count_sat", {62'd0, bus_s.op_count}, 64'((m_count > 3) ? 3 : m_count));
    endtask

    initial begin
        int ops_before;
        m_full  = 0;
        m_data  = 0;
        m_src   = 0;
        m_last  = 1;
        m_count = 0;
        reset   = 1'b1;
        bus_m.req0_valid = 0; bus_m.req1_valid = 0;
        bus_m.req0_a = 0; bus_m.req0_b = 0; bus_m.req0_bubbles = 0;
        bus_m.req1_a = 0; bus_m.req1_b = 0; bus_m.req1_bubbles = 0;
        bus_m.res_ready = 0;

        // Reset held two cycles with both requesters asking.
        repeat (2) applyStimulus(1, 1, 1, 8'h11, 8'h22, 2'b00, 8'h33, 8'h44, 2'b00, 1);

        applyStimulus(0, 1, 0, 8'h0F, 8'hF0, 2'b00, 8'h00, 8'h00, 2'b00, 1);
        checkOutput("first_grant", {63'd0, obs_r0}, 64'd1);
        checkOutput("first_data", {56'd0, bus_m.res_data}, 64'hFF);

        applyStimulus(0, 0, 1, 8'h00, 8'h00, 2'b00, 8'h0F, 8'h00, 2'b01, 1);
`ifdef GATE_ARB_BUBBLE_EN
        checkOutput("bubble_data", {56'd0, bus_m.res_data}, 64'hF0);
`else
        checkOutput("bubble_data", {56'd0, bus_m.res_data}, 64'h0F);
`endif

        // Six cycles of contention with the consumer always ready.
        ops_before = int'(bus_m.op_count);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(0, 1, 1, 8'($urandom), 8'($urandom), 2'($urandom),
                          8'($urandom), 8'($urandom), 2'($urandom), 1);
            checkOutput("rr_order", {63'd0, obs_r0}, {63'd0, (i % 2) == 0});
        end
        applyStimulus(0, 0, 0, 8'h00, 8'h00, 2'b00, 8'h00, 8'h00, 2'b00, 1);
        checkOutput("contention_ops", 64'(int'(bus_m.op_count) - ops_before), 64'd7);

        // Back-pressure: load one result, stall three cycles, then release.
        applyStimulus(0, 1, 0, 8'hA5, 8'h00, 2'b00, 8'h00, 8'h00, 2'b00, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 1, 8'($urandom), 8'($urandom), 2'b00,
                          8'($urandom), 8'($urandom), 2'b00, 0);
            checkOutput("stall_data", {56'd0, bus_m.res_data}, 64'hA5);
        end
        applyStimulus(0, 1, 1, 8'h01, 8'h02, 2'b00, 8'h40, 8'h08, 2'b00, 1);
        checkOutput("release_grant", {63'd0, obs_r1}, 64'd1);

        // Reset while a result is pending.
        applyStimulus(0, 1, 0, 8'h3C, 8'h00, 2'b00, 8'h00, 8'h00, 2'b00, 0);
        applyStimulus(1, 1, 1, 8'h3C, 8'h00, 2'b00, 8'h00, 8'h00, 2'b00, 1);
        checkOutput("midreset_valid", {63'd0, bus_m.res_valid}, 64'd0);
        checkOutput("midreset_count", {48'd0, bus_m.op_count}, 64'd0);
        applyStimulus(0, 1, 1, 8'h01, 8'h00, 2'b00, 8'h02, 8'h00, 2'b00, 1);
        checkOutput("post_reset_grant", {63'd0, obs_r0}, 64'd1);

        for (int i = 0; i < 300; i++) begin
            applyStimulus(($urandom_range(0, 49) == 0), 1'($urandom), 1'($urandom),
                          8'($urandom), 8'($urandom), 2'($urandom),
                          8'($urandom), 8'($urandom), 2'($urandom),
                          ($urandom_range(0, 3) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
